// File: rtl/seg_scan_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module   : seg_scan_ctrl
//  Brief    : Time-multiplexed 7-segment scan controller. Walks a latched
//             multi-digit BCD value one digit at a time with a guard gap,
//             leading-zero blanking, decimal points and frame-aligned updates.
//  Revision : 1.0  initial release
//------------------------------------------------------------------------------
module seg_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int CLK_DIV    = 100000,
   parameter int GUARD_CYC  = 2,
   parameter int BLANK_LZ   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] din,
   input  logic [NUM_DIGITS-1:0]   dp_en,
   input  logic                    load,
   output logic                    pending,
   output logic [3:0]              digit_code,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    dp_n,
   output logic                    blank,
   output logic                    err,
   output logic                    frame_done
);

   localparam int c_CNT_MAX = (CLK_DIV > GUARD_CYC) ? CLK_DIV : GUARD_CYC;
   localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
   localparam int c_IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [c_CNT_W-1:0]    c_SHOW_LAST  = c_CNT_W'(CLK_DIV - 1);
   localparam logic [c_CNT_W-1:0]    c_GUARD_LAST = c_CNT_W'(GUARD_CYC - 1);
   localparam logic [c_IDX_W-1:0]    c_IDX_LAST   = c_IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] c_ALL_OFF    = {NUM_DIGITS{1'b1}};
   // A zero shadow still blanks every digit above digit 0 when LZ blanking is on
   localparam logic [NUM_DIGITS-1:0] c_ZERO_MASK  =
      (BLANK_LZ != 0) ? ~NUM_DIGITS'(1) : {NUM_DIGITS{1'b0}};

   typedef enum logic [0:0] {
      ST_GUARD = 1'b0,
      ST_SHOW  = 1'b1
   } state_t;

   state_t                  r_state, w_state_nx;
   logic [c_CNT_W-1:0]      r_cnt, w_cnt_nx;
   logic [c_IDX_W-1:0]      r_idx, w_idx_nx;
   logic                    w_wrap;

   logic [4*NUM_DIGITS-1:0] r_pend_val, r_shd_val;
   logic [NUM_DIGITS-1:0]   r_pend_dp, r_shd_dp, r_shd_blank;
   logic [NUM_DIGITS-1:0]   w_mask;
   logic                    w_err_nx;

   // Phase state, phase counter and digit index register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_GUARD;
         r_cnt   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_idx   <= w_idx_nx;
      end
   end

   // Next phase: GUARD for GUARD_CYC cycles, SHOW for CLK_DIV cycles, then next digit
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt + 1'b1;
      w_idx_nx   = r_idx;
      w_wrap     = 1'b0;
      case (r_state)
         ST_GUARD: begin
            if (r_cnt == c_GUARD_LAST) begin
               w_state_nx = ST_SHOW;
               w_cnt_nx   = '0;
            end
         end
         ST_SHOW: begin
            if (r_cnt == c_SHOW_LAST) begin
               w_state_nx = ST_GUARD;
               w_cnt_nx   = '0;
               if (r_idx == c_IDX_LAST) begin
                  w_idx_nx = '0;
                  w_wrap   = 1'b1;
               end else begin
                  w_idx_nx = r_idx + 1'b1;
               end
            end
         end
         default: begin
            w_state_nx = ST_GUARD;
            w_cnt_nx   = '0;
            w_idx_nx   = '0;
         end
      endcase
   end

   // Blank mask of the pending value: leading zeros above the highest
   // non-zero or dp-marked digit, plus any non-BCD nibble
   always_comb begin
      logic       v_lead;
      logic [3:0] v_nib;
      w_mask   = '0;
      w_err_nx = 1'b0;
      v_lead   = 1'b1;
      v_nib    = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         v_nib = r_pend_val[4*i +: 4];
         if (i == 0 || v_nib != 4'd0 || r_pend_dp[i]) begin
            v_lead = 1'b0;
         end
         w_mask[i] = (v_lead && (BLANK_LZ != 0)) || (v_nib > 4'd9);
         if (v_nib > 4'd9) begin
            w_err_nx = 1'b1;
         end
      end
   end

   // Load capture into pending; pending-to-shadow transfer only on the frame wrap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend_val  <= '0;
         r_pend_dp   <= '0;
         pending     <= 1'b0;
         r_shd_val   <= '0;
         r_shd_dp    <= '0;
         r_shd_blank <= c_ZERO_MASK;
         err         <= 1'b0;
      end else begin
         if (w_wrap && pending) begin
            r_shd_val   <= r_pend_val;
            r_shd_dp    <= r_pend_dp;
            r_shd_blank <= w_mask;
            err         <= w_err_nx;
            pending     <= 1'b0;
         end
         // A coincident load refills pending after the older value moved on
         if (load) begin
            r_pend_val <= din;
            r_pend_dp  <= dp_en;
            pending    <= 1'b1;
         end
      end
   end

   // Display outputs registered from the upcoming phase so they align with it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an         <= c_ALL_OFF;
         digit_code <= 4'd0;
         dp_n       <= 1'b1;
         blank      <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= w_wrap;
         if (w_state_nx == ST_SHOW && !r_shd_blank[w_idx_nx]) begin
            an         <= ~(NUM_DIGITS'(1) << w_idx_nx);
            digit_code <= r_shd_val[{w_idx_nx, 2'b00} +: 4];
            dp_n       <= ~r_shd_dp[w_idx_nx];
            blank      <= 1'b0;
         end else if (w_state_nx == ST_SHOW) begin
            an         <= c_ALL_OFF;
            digit_code <= 4'd0;
            dp_n       <= 1'b1;
            blank      <= 1'b1;
         end else begin
            an         <= c_ALL_OFF;
            digit_code <= 4'd0;
            dp_n       <= 1'b1;
            blank      <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
